uart_frame_checker: RTL and testbench
=====================================

UART_FRAME_CHECKER -- requirements
Module: uart_frame_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set data bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, SHALL set stop bits per frame; legal values 1 or 2.
REQ-003 CLK  input  1  SHALL be the clock; all state updates on rising edge.
REQ-004 RST  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 frame_start  input  1  SHALL be a one-cycle pulse marking a validated start bit.
REQ-006 bit_valid  input  1  SHALL be a one-cycle strobe qualifying sampled_bit.
REQ-007 sampled_bit  input  1  SHALL be the majority-sampled line value.
REQ-008 parity_enable  input  1  SHALL select whether a parity bit follows the data bits.
REQ-009 parity_type  input  1  SHALL select parity: 0 = even, 1 = odd.
REQ-010 data_out  output  DATA_WIDTH  SHALL be the last received data word, LSB first on the line.
REQ-011 frame_done, data_valid  output  1 each  SHALL be one-cycle completion pulses.
REQ-012 parity_error, stop_error  output  1 each  SHALL be the error status of the last completed frame.
REQ-013 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-014 err_count  output  8, err_count_clr  input  1  SHALL be the error-counter port pair (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: frame_start SHALL move to DATA, clear bit counter and stop-error accumulator, and latch parity_enable and parity_type; a bit_valid in the same cycle SHALL be ignored.
REQ-017 frame_start outside IDLE SHALL be ignored.
REQ-018 DATA: each bit_valid SHALL shift sampled_bit into bit position = counter (LSB first) and XOR it into a running parity.
REQ-019 On the DATA_WIDTH-th data bit, the FSM SHALL move to PARITY if latched parity_enable = 1, otherwise to STOP.
REQ-020 PARITY: on bit_valid, the parity error SHALL be computed as (running XOR ^ sampled_bit) != latched parity_type, and the FSM SHALL move to STOP; with parity disabled, the parity error SHALL be 0.
REQ-021 STOP: each bit_valid SHALL OR (~sampled_bit) into the stop-error accumulator; after STOP_BITS stop bits the FSM SHALL return to IDLE.
REQ-022 On the edge consuming the final stop bit, frame_done SHALL pulse high for exactly one cycle starting the following cycle, i.e. latency of 1 cycle from the final bit_valid.
REQ-023 In that same frame_done cycle, data_out, parity_error and stop_error SHALL update; they SHALL hold until the next frame_done.
REQ-024 data_valid SHALL equal frame_done AND NOT parity_error AND NOT stop_error for the frame.
REQ-025 Cycles without bit_valid SHALL leave all state unchanged.
REQ-026 A second stop bit of 0 with a first stop bit of 1 SHALL still set stop_error (STOP_BITS = 2).

Reset
REQ-027 RST low SHALL immediately force IDLE, counters 0, data_out 0, and all 1-bit outputs 0, with err_count = 0.
REQ-028 Reset mid-frame SHALL discard the partial frame with no frame_done pulse.

Configuration
REQ-029 Macro UART_FRAME_ERR_CNT_EN defined: err_count SHALL increment by 1 on every frame_done with parity_error or stop_error set, SHALL saturate at 255, and SHALL clear synchronously to 0 on err_count_clr, which has priority over increment.
REQ-030 Macro undefined: err_count SHALL be constant 0, err_count_clr SHALL be ignored, and no counter logic SHALL be present.

Verification
REQ-031 Defaults, frame 0xA5, stop = 1, parity off -> data_out = 0xA5, frame_done = 1, data_valid = 1, both errors 0.
REQ-032 Parity even, 0x07 with parity bit 0 -> parity_error = 1, data_valid = 0, data_out = 0x07.
REQ-033 STOP_BITS = 2, 0x3C, stop bits 1 then 0 -> stop_error = 1; the next good frame 0x55 -> stop_error = 0.
REQ-034 RST asserted after 4 data bits -> busy = 0 immediately, no frame_done; the next full frame 0x81 -> data_out = 0x81.
REQ-035 frame_start pulsed during DATA -> ignored; the frame completes with correct data.
REQ-036 With UART_FRAME_ERR_CNT_EN, 300 stop-error frames -> err_count = 255; err_count_clr -> 0; without the macro -> err_count stays 0.

Source files
------------

// File: rtl/uart_frame_checker_if.sv
// Bundle of framing inputs and frame-result outputs for uart_frame_checker.
// The master side drives the sampled line; the slave side is the checker.
interface uart_frame_checker_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  frame_start;
    logic                  bit_valid;
    logic                  sampled_bit;
    logic                  parity_enable;
    logic                  parity_type;
    logic                  err_count_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  frame_done;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;
    logic                  busy;
    logic [7:0]            err_count;

    modport master (
        output frame_start, bit_valid, sampled_bit, parity_enable, parity_type, err_count_clr,
        input  data_out, frame_done, data_valid, parity_error, stop_error, busy, err_count
    );

    modport slave (
        input  frame_start, bit_valid, sampled_bit, parity_enable, parity_type, err_count_clr,
        output data_out, frame_done, data_valid, parity_error, stop_error, busy, err_count
    );
endinterface

// File: rtl/uart_frame_checker.sv
// Turns majority-sampled UART bits into data words with parity and stop-bit checks.
// Define UART_FRAME_ERR_CNT_EN to add the saturating errored-frame counter.
module uart_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                CLK,
    input  logic                RST,
    uart_frame_checker_if.slave bus
);
    // state  | meaning
    // IDLE   | waiting for frame_start
    // DATA   | collecting DATA_WIDTH data bits, LSB first
    // PARITY | waiting for the parity bit
    // STOP   | collecting STOP_BITS stop bits
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    logic [1:0]            state;
    logic [3:0]            bit_cnt;
    logic                  stop_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  run_par;
    logic                  par_en_q;
    logic                  par_type_q;
    logic                  par_err_q;
    logic                  stop_err_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  done_q;
    logic                  valid_q;
    logic                  par_err_out;
    logic                  stop_err_out;
    logic                  stop_err_next;

    assign stop_err_next = stop_err_q | ~bus.sampled_bit;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            stop_cnt     <= 1'b0;
            shift_q      <= '0;
            run_par      <= 1'b0;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            data_q       <= '0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            par_err_out  <= 1'b0;
            stop_err_out <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        state      <= DATA;
                        bit_cnt    <= 4'd0;
                        stop_cnt   <= 1'b0;
                        shift_q    <= '0;
                        run_par    <= 1'b0;
                        par_err_q  <= 1'b0;
                        stop_err_q <= 1'b0;
                        par_en_q   <= bus.parity_enable;
                        par_type_q <= bus.parity_type;
                    end
                end
                DATA: begin
                    if (bus.bit_valid) begin
                        // Shifting in at the MSB leaves the first line bit at bit 0 after DATA_WIDTH bits.
                        shift_q <= {bus.sampled_bit, shift_q[DATA_WIDTH-1:1]};
                        run_par <= run_par ^ bus.sampled_bit;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= 4'd0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bus.bit_valid) begin
                        par_err_q <= (run_par ^ bus.sampled_bit) != par_type_q;
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (bus.bit_valid) begin
                        stop_err_q <= stop_err_next;
                        if (stop_cnt == LAST_STOP) begin
                            state        <= IDLE;
                            stop_cnt     <= 1'b0;
                            done_q       <= 1'b1;
                            valid_q      <= ~par_err_q & ~stop_err_next;
                            data_q       <= shift_q;
                            par_err_out  <= par_err_q;
                            stop_err_out <= stop_err_next;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out     = data_q;
    assign bus.frame_done   = done_q;
    assign bus.data_valid   = valid_q;
    assign bus.parity_error = par_err_out;
    assign bus.stop_error   = stop_err_out;
    assign bus.busy         = (state != IDLE);

`ifdef UART_FRAME_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_cnt_q <= 8'd0;
        end else if (bus.err_count_clr) begin
            err_cnt_q <= 8'd0;
        end else if (done_q && (par_err_out || stop_err_out) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_count = err_cnt_q;
`else
    logic unused_err_count_clr;
    assign unused_err_count_clr = bus.err_count_clr;
    assign bus.err_count        = 8'd0;
`endif

endmodule

// File: tb/tb_uart_frame_checker.sv
// Scoreboard bench for uart_frame_checker: one default instance and one with two stop bits.
module tb_uart_frame_checker;
`ifdef UART_FRAME_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       se;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_frame_checker_if #(.DATA_WIDTH(8)) if_a ();
    uart_frame_checker_if #(.DATA_WIDTH(8)) if_b ();

    uart_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut_a (.CLK(CLK), .RST(RST), .bus(if_a));
    uart_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut_b (.CLK(CLK), .RST(RST), .bus(if_b));

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t last_e[2];
    bit   have_last[2];
    bit   prev_done[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic string pfx(input int k);
        return (k == 0) ? "a_" : "b_";
    endfunction

    function automatic logic [11:0] obs(input int k);
        if (k == 0)
            return {if_a.data_out, if_a.frame_done, if_a.data_valid, if_a.parity_error, if_a.stop_error};
        return {if_b.data_out, if_b.frame_done, if_b.data_valid, if_b.parity_error, if_b.stop_error};
    endfunction

    function automatic logic busy_of(input int k);
        return (k == 0) ? if_a.busy : if_b.busy;
    endfunction

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input int k, input logic fs, input logic bv, input logic sb);
        if (k == 0) begin
            if_a.frame_start = fs; if_a.bit_valid = bv; if_a.sampled_bit = sb;
        end else begin
            if_b.frame_start = fs; if_b.bit_valid = bv; if_b.sampled_bit = sb;
        end
    endtask

    task automatic set_ctl(input int k, input logic pen, input logic pt);
        if (k == 0) begin
            if_a.parity_enable = pen; if_a.parity_type = pt;
        end else begin
            if_b.parity_enable = pen; if_b.parity_type = pt;
        end
    endtask

    task automatic gap_cycles(input int k, input int gap);
        for (int g = 0; g < gap; g++) begin
            set_in(k, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            step;
        end
    endtask

    // Drives one frame and returns in the cycle where frame_done must be high.
    task automatic send_frame(input int k, input logic [7:0] d, input logic pen, input logic pt,
                              input logic pbit, input logic s0, input logic s1,
                              input int gap, input int inj_at);
        exp_t e;
        int   nstop;
        nstop = (k == 1) ? 2 : 1;
        e.data = d;
        e.pe   = pen && (((^d) ^ pbit) != pt);
        e.se   = !s0 || (nstop == 2 && !s1);
        if (k == 0) q_a.push_back(e); else q_b.push_back(e);
        set_ctl(k, pen, pt);
        set_in(k, 1'b1, 1'b1, 1'b1);
        step;
        set_ctl(k, !pen, !pt);
        check({pfx(k), "busy_after_start"}, 32'(busy_of(k)), 32'd1);
        for (int i = 0; i < 8; i++) begin
            gap_cycles(k, gap);
            set_in(k, (i == inj_at), 1'b1, d[i]);
            step;
        end
        if (pen) begin
            gap_cycles(k, gap);
            set_in(k, 1'b0, 1'b1, pbit);
            step;
        end
        for (int s = 0; s < nstop; s++) begin
            gap_cycles(k, gap);
            set_in(k, 1'b0, 1'b1, (s == 0) ? s0 : s1);
            step;
        end
        set_in(k, 1'b0, 1'b0, 1'b0);
        check({pfx(k), "done_latency"}, 32'(obs(k)), 32'({e.data, 1'b1, ~(e.pe | e.se), e.pe, e.se}));
        check({pfx(k), "busy_after_done"}, 32'(busy_of(k)), 32'd0);
    endtask

    task automatic mon(input int k);
        logic [11:0] o;
        exp_t        e;
        bit          empty;
        o = obs(k);
        if (!RST) begin
            have_last[k] = 1'b0;
            prev_done[k] = 1'b0;
            return;
        end
        if (o[3]) begin
            check({pfx(k), "done_width"}, 32'(prev_done[k]), 32'd0);
            empty = (k == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
            if (empty) begin
                check({pfx(k), "spurious_done"}, 32'(o[3]), 32'd0);
            end else begin
                if (k == 0) e = q_a.pop_front(); else e = q_b.pop_front();
                check({pfx(k), "frame_result"}, 32'({o[11:4], o[2:0]}),
                      32'({e.data, ~(e.pe | e.se), e.pe, e.se}));
                last_e[k]    = e;
                have_last[k] = 1'b1;
            end
        end else begin
            check({pfx(k), "dv_outside_done"}, 32'(o[2]), 32'd0);
            if (have_last[k])
                check({pfx(k), "hold"}, 32'({o[11:4], o[1:0]}),
                      32'({last_e[k].data, last_e[k].pe, last_e[k].se}));
        end
        prev_done[k] = o[3];
    endtask

    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) mon(k);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(0, 1'b0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0, 1'b0);
        set_ctl(0, 1'b0, 1'b0);
        set_ctl(1, 1'b0, 1'b0);
        if_a.err_count_clr = 1'b0;
        if_b.err_count_clr = 1'b0;
        #12;
        check("reset_outputs_a", 32'({obs(0), if_a.busy}), 32'd0);
        check("reset_outputs_b", 32'({obs(1), if_b.busy}), 32'd0);
        check("reset_err_count", 32'(if_a.err_count), 32'd0);
        step;
        RST = 1'b1;
        step;

        send_frame(0, 8'hA5, 0, 0, 0, 1, 1, 0, -1);
        send_frame(0, 8'h07, 1, 0, 0, 1, 1, 0, -1);
        send_frame(0, 8'h07, 1, 0, 1, 1, 1, 1, -1);
        send_frame(0, 8'h5A, 1, 1, 1, 1, 1, 0, -1);
        send_frame(0, 8'h5A, 1, 1, 0, 1, 1, 2, -1);
        send_frame(0, 8'hC3, 0, 0, 0, 0, 1, 0, -1);
        send_frame(0, 8'h96, 1, 0, 1, 0, 1, 0, 3);
        send_frame(0, 8'h3E, 0, 0, 0, 1, 1, 0, 5);

        send_frame(1, 8'h3C, 0, 0, 0, 1, 0, 0, -1);
        send_frame(1, 8'h55, 0, 0, 0, 1, 1, 0, -1);
        send_frame(1, 8'hF0, 1, 1, 1, 0, 1, 1, -1);
        send_frame(1, 8'h0F, 1, 0, 0, 1, 1, 0, 2);

        for (int i = 0; i < 8; i++) begin
            send_frame(i % 2, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                       $urandom_range(0, 1), -1);
        end
        step;

        // Reset after four data bits of a partial frame.
        set_ctl(0, 1'b0, 1'b0);
        set_in(0, 1'b1, 1'b0, 1'b0);
        step;
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1'b0, 1'b1, 1'(i));
            step;
        end
        set_in(0, 1'b0, 1'b0, 1'b0);
        check("busy_mid_frame", 32'(if_a.busy), 32'd1);
        RST = 1'b0;
        #1;
        check("reset_mid_frame", 32'({obs(0), if_a.busy}), 32'd0);
        step;
        RST = 1'b1;
        step;
        step;
        send_frame(0, 8'h81, 0, 0, 0, 1, 1, 0, -1);
        step;

        if_a.err_count_clr = 1'b1;
        step;
        if_a.err_count_clr = 1'b0;
        check("err_clr", 32'(if_a.err_count), 32'd0);
        send_frame(0, 8'h11, 0, 0, 0, 0, 1, 0, -1);
        step;
        check("err_inc", 32'(if_a.err_count), ERR_EN ? 32'd1 : 32'd0);
        send_frame(0, 8'h22, 0, 0, 0, 0, 1, 0, -1);
        if_a.err_count_clr = 1'b1;
        step;
        if_a.err_count_clr = 1'b0;
        check("err_clr_priority", 32'(if_a.err_count), 32'd0);
        for (int i = 0; i < 300; i++)
            send_frame(0, 8'(i), 0, 0, 0, 0, 1, 0, -1);
        step;
        step;
        check("err_saturate", 32'(if_a.err_count), ERR_EN ? 32'd255 : 32'd0);
        if_a.err_count_clr = 1'b1;
        step;
        if_a.err_count_clr = 1'b0;
        check("err_clr_after_sat", 32'(if_a.err_count), 32'd0);

        step;
        step;
        check("a_queue_drained", q_a.size(), 32'd0);
        check("b_queue_drained", q_b.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
